// File: rtl/core_pkg.sv
// Shared core definitions: pipeline state encoding, register address width,
// divide latency default and the operand-match helper used by hazard_ctrl.
package core_pkg;

  localparam int REG_ADDR_W       = 5;
  localparam int FDIV_LAT_DEFAULT = 4;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    SLEEP = 1'b1
  } core_state_e;

  // An ID source depends on an in-flight load when it is read, names the same
  // register file and address, and is not the hard-wired integer x0.
  function automatic logic src_match(
    input logic                  use_src,
    input logic [REG_ADDR_W-1:0] rs,
    input logic                  src_fp,
    input logic [REG_ADDR_W-1:0] rd,
    input logic                  ld_fp
  );
    return use_src && (rs == rd) && (src_fp == ld_fp) &&
           (ld_fp || (rd != '0));
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-unit signal bundle; master is the pipeline datapath,
// slave is hazard_ctrl.
interface hazard_ctrl_if;
  import core_pkg::*;

  logic                  IM_stall;
  logic                  DM_stall;
  logic                  jb;
  logic                  D_WFI;
  logic                  D_MRET;
  logic                  irq_pending;
  logic                  E_ld;
  logic                  E_ld_fp;
  logic [REG_ADDR_W-1:0] E_rd;
  logic                  E_fdiv;
  logic [REG_ADDR_W-1:0] D_rs1;
  logic [REG_ADDR_W-1:0] D_rs2;
  logic [1:0]            D_use;
  logic [1:0]            D_src_fp;

  logic                  hold_E;
  logic                  hold_FD;
  logic                  flush_E;
  logic                  flush_D;
  logic                  interrupt_taken;
  logic                  interrupt_taken_reg;
  logic                  wfi_sleep;
  logic                  fdiv_busy;

  modport master (
    output IM_stall, DM_stall, jb, D_WFI, D_MRET, irq_pending,
           E_ld, E_ld_fp, E_rd, E_fdiv, D_rs1, D_rs2, D_use, D_src_fp,
    input  hold_E, hold_FD, flush_E, flush_D, interrupt_taken,
           interrupt_taken_reg, wfi_sleep, fdiv_busy
  );

  modport slave (
    input  IM_stall, DM_stall, jb, D_WFI, D_MRET, irq_pending,
           E_ld, E_ld_fp, E_rd, E_fdiv, D_rs1, D_rs2, D_use, D_src_fp,
    output hold_E, hold_FD, flush_E, flush_D, interrupt_taken,
           interrupt_taken_reg, wfi_sleep, fdiv_busy
  );

endinterface

// File: rtl/fdiv_occupancy_cnt.sv
// Down-counter tracking how long an FP divide still occupies EXE; it freezes
// while memory is stalled so stall cycles lengthen the occupancy.
module fdiv_occupancy_cnt
  import core_pkg::*;
#(
  parameter int FDIV_LAT = FDIV_LAT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic mem_hold,
  output logic busy
);

  logic [3:0] cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= 4'd0;
    end else if (!mem_hold) begin
      if (start && (cnt_reg == 4'd0)) begin
        cnt_reg <= 4'(FDIV_LAT - 1);
      end else if (cnt_reg != 4'd0) begin
        cnt_reg <= cnt_reg - 4'd1;
      end
    end
  end

  assign busy = (cnt_reg != 4'd0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: load-use interlock, branch/trap flushes, WFI sleep FSM.
// Multi-cycle FP divide occupancy is built only when FDIV_MULTICYCLE_EN is defined.
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int FDIV_LAT = FDIV_LAT_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  hz
);

  localparam logic [0:0] ST_RUN   = RUN;
  localparam logic [0:0] ST_SLEEP = SLEEP;

  logic [0:0]            state_reg;
  logic [0:0]            state_next;
  logic                  irq_taken_reg;
  logic                  mem_hold;
  logic                  fdiv_busy;
  logic                  hold_e;
  logic                  load_use;
  logic                  irq_take;
  logic [REG_ADDR_W-1:0] d_rs [2];
  logic [1:0]            src_hit;

  assign mem_hold = hz.IM_stall | hz.DM_stall;

  assign d_rs[0] = hz.D_rs1;
  assign d_rs[1] = hz.D_rs2;

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_src
    assign src_hit[gi] = src_match(hz.D_use[gi], d_rs[gi], hz.D_src_fp[gi],
                                   hz.E_rd, hz.E_ld_fp);
  end

`ifdef FDIV_MULTICYCLE_EN
  fdiv_occupancy_cnt #(
    .FDIV_LAT (FDIV_LAT)
  ) u_fdiv_cnt (
    .clk      (clk),
    .rst      (rst),
    .start    (hz.E_fdiv),
    .mem_hold (mem_hold),
    .busy     (fdiv_busy)
  );
`else
  // Single-cycle FPU: the divide flag carries no timing information.
  logic unused_fdiv;
  assign unused_fdiv = hz.E_fdiv;
  assign fdiv_busy   = 1'b0;
`endif

  assign hold_e   = mem_hold | fdiv_busy;
  assign load_use = hz.E_ld & ~hz.jb & (|src_hit);
  // Back-to-back traps are suppressed while the previous entry is still flushing.
  assign irq_take = hz.irq_pending & ~hold_e & ~hz.jb & ~irq_taken_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_RUN: begin
        if (hz.D_WFI && !hz.jb && !hz.irq_pending && !hold_e) begin
          state_next = ST_SLEEP;
        end
      end
      ST_SLEEP: begin
        if (hz.irq_pending && !mem_hold) begin
          state_next = ST_RUN;
        end
      end
      default: state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_RUN;
      irq_taken_reg <= 1'b0;
    end else if (!mem_hold) begin
      state_reg     <= state_next;
      irq_taken_reg <= irq_take;
    end
  end

  assign hz.hold_E              = hold_e;
  assign hz.hold_FD             = hold_e | load_use | hz.wfi_sleep;
  assign hz.flush_E             = ~hold_e & (hz.jb | load_use | irq_take |
                                             irq_taken_reg | hz.D_MRET | hz.D_WFI);
  assign hz.flush_D             = ~hold_e & (hz.jb | irq_take);
  assign hz.interrupt_taken     = irq_take;
  assign hz.interrupt_taken_reg = irq_taken_reg;
  assign hz.wfi_sleep           = (state_reg == ST_SLEEP);
  assign hz.fdiv_busy           = fdiv_busy;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl; divide expectations follow
// whether FDIV_MULTICYCLE_EN is defined for the build.
module tb_hazard_ctrl;
  import core_pkg::*;

`ifdef FDIV_MULTICYCLE_EN
  localparam bit FDIV_ON = 1'b1;
`else
  localparam bit FDIV_ON = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  hazard_ctrl_if hz ();

  hazard_ctrl #(
    .FDIV_LAT (4)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz.slave)
  );

  // {hold_E, hold_FD, flush_E, flush_D, interrupt_taken, interrupt_taken_reg, wfi_sleep, fdiv_busy}
  logic [7:0] outs;
  assign outs = {hz.hold_E, hz.hold_FD, hz.flush_E, hz.flush_D,
                 hz.interrupt_taken, hz.interrupt_taken_reg, hz.wfi_sleep, hz.fdiv_busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end else begin
      $display("ok   %s: %b", tag, got);
    end
  endtask

  task automatic idle();
    hz.IM_stall = 0; hz.DM_stall = 0; hz.jb = 0; hz.D_WFI = 0; hz.D_MRET = 0;
    hz.irq_pending = 0; hz.E_ld = 0; hz.E_ld_fp = 0; hz.E_rd = '0; hz.E_fdiv = 0;
    hz.D_rs1 = '0; hz.D_rs2 = '0; hz.D_use = 2'b00; hz.D_src_fp = 2'b00;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic load(input logic [4:0] rd, input logic ld_fp, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [1:0] use_v, input logic [1:0] sfp);
    idle();
    hz.E_ld = 1; hz.E_rd = rd; hz.E_ld_fp = ld_fp;
    hz.D_rs1 = rs1; hz.D_rs2 = rs2; hz.D_use = use_v; hz.D_src_fp = sfp;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic eb;
    logic st;
    logic [1:0] stall_pat [6];
    logic [5:0] busy_pat;
    n_tests = 0;
    n_fail  = 0;
    idle();
    rst = 1'b1;
    #12;
    chk("reset", outs, 8'b0000_0000);
    rst = 1'b0;

    // Load-use interlock and its qualifiers
    tick(); load(5'd5, 0, 5'd5, 5'd0, 2'b01, 2'b00); settle();
    chk("lu_rs1", outs, 8'b0110_0000);
    tick(); idle(); settle();
    chk("lu_bubble", outs, 8'b0000_0000);
    tick(); load(5'd7, 0, 5'd0, 5'd7, 2'b10, 2'b00); settle();
    chk("lu_rs2", outs, 8'b0110_0000);
    tick(); load(5'd7, 0, 5'd0, 5'd7, 2'b01, 2'b00); settle();
    chk("lu_rs2_unused", outs, 8'b0000_0000);
    tick(); load(5'd0, 0, 5'd0, 5'd0, 2'b01, 2'b00); settle();
    chk("lu_x0", outs, 8'b0000_0000);
    tick(); load(5'd5, 1, 5'd5, 5'd0, 2'b01, 2'b00); settle();
    chk("lu_fp_mismatch", outs, 8'b0000_0000);
    tick(); load(5'd0, 1, 5'd0, 5'd0, 2'b01, 2'b01); settle();
    chk("lu_f0", outs, 8'b0110_0000);
    tick(); load(5'd5, 0, 5'd5, 5'd0, 2'b01, 2'b00); hz.jb = 1; settle();
    chk("lu_jb", outs, 8'b0011_0000);
    hz.DM_stall = 1; settle();
    chk("memhold_jb", outs, 8'b1100_0000);
    tick(); idle(); hz.IM_stall = 1; hz.irq_pending = 1; settle();
    chk("memhold_irq", outs, 8'b1100_0000);
    tick(); idle(); hz.D_MRET = 1; settle();
    chk("mret", outs, 8'b0010_0000);

    // WFI sleep and interrupt wake-up
    tick(); idle(); hz.D_WFI = 1; settle();
    chk("wfi_enter", outs, 8'b0010_0000);
    tick(); idle(); settle();
    chk("wfi_sleep", outs, 8'b0100_0010);
    for (int i = 0; i < 9; i++) begin
      tick(); settle();
      chk($sformatf("sleep_%0d", i), outs, 8'b0100_0010);
    end
    tick(); hz.DM_stall = 1; hz.irq_pending = 1; settle();
    chk("sleep_irq_memhold", outs, 8'b1100_0010);
    tick(); hz.DM_stall = 0; settle();
    chk("wake_take", outs, 8'b0111_1010);
    tick(); hz.irq_pending = 0; settle();
    chk("wake_reg", outs, 8'b0010_0100);
    tick(); settle();
    chk("wake_done", outs, 8'b0000_0000);

    // Simultaneous jb, WFI and interrupt
    tick(); idle(); hz.jb = 1; hz.D_WFI = 1; hz.irq_pending = 1; settle();
    chk("simul_jb", outs, 8'b0011_0000);
    tick(); hz.jb = 0; hz.D_WFI = 0; settle();
    chk("simul_irq", outs, 8'b0011_1000);
    tick(); hz.irq_pending = 0; settle();
    chk("simul_reg", outs, 8'b0010_0100);
    tick(); hz.irq_pending = 1; hz.D_MRET = 1; settle();
    chk("irq_mret", outs, 8'b0011_1000);
    tick(); idle(); settle();
    chk("irq_mret_reg", outs, 8'b0010_0100);

    // Divide occupancy without stalls: busy cycles 1..3
    tick(); idle(); hz.E_fdiv = 1; settle();
    chk("fdiv_issue", outs, 8'b0000_0000);
    for (int c = 1; c <= 4; c++) begin
      tick(); idle(); settle();
      eb = FDIV_ON && (c <= 3);
      chk($sformatf("fdiv_c%0d", c), outs, {eb, eb, 5'b0, eb});
    end

    // Divide with two stall cycles mid-divide: busy cycles 1..5
    stall_pat = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd0};
    busy_pat  = 6'b011111;
    tick(); idle(); hz.E_fdiv = 1; settle();
    chk("fdivs_issue", outs, 8'b0000_0000);
    for (int c = 1; c <= 6; c++) begin
      tick(); idle();
      st = (c <= 5) ? stall_pat[c][0] : 1'b0;
      hz.DM_stall = st;
      settle();
      eb = FDIV_ON && (c <= 5) && busy_pat[c-1];
      chk($sformatf("fdivs_c%0d", c), outs, {eb | st, eb | st, 5'b0, eb});
    end

    // Asynchronous reset mid-sleep and mid-divide
    tick(); idle(); hz.D_WFI = 1; hz.E_fdiv = 1; settle();
    chk("rst_setup", outs, 8'b0010_0000);
    tick(); idle(); settle();
    chk("rst_pre", outs, {FDIV_ON, 1'b1, 4'b0000, 1'b1, FDIV_ON});
    rst = 1'b1; #1;
    chk("rst_async", outs, 8'b0000_0000);
    tick(); rst = 1'b0; settle();
    chk("rst_release", outs, 8'b0000_0000);
    tick(); settle();
    chk("rst_no_residual", outs, 8'b0000_0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter: FDIV_LAT, default 4, EXE occupancy in cycles of an FP divide (legal range 2..15).
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1: clock.
- rst, in, 1: reset, asynchronous, active-high.
- IM_stall, in, 1: instruction memory wait.
- DM_stall, in, 1: data memory wait.
- jb, in, 1: jump or taken branch resolved in EXE.
- D_WFI, in, 1: WFI decoded in ID.
- D_MRET, in, 1: MRET decoded in ID.
- irq_pending, in, 1: enabled interrupt pending from CSR.
- E_ld, in, 1: EXE holds a load.
- E_ld_fp, in, 1: that load targets the FP file.
- E_rd, in, 5: destination of the EXE instruction.
- E_fdiv, in, 1: EXE holds fdiv.s.
- D_rs1, in, 5: ID source 1.
- D_rs2, in, 5: ID source 2.
- D_use, in, 2: ID reads rs1 (bit 0) and rs2 (bit 1).
- D_src_fp, in, 2: per-source FP-file flag.
- hold_E, out, 1: freeze the ID/EXE register.
- hold_FD, out, 1: freeze PC and IF/ID.
- flush_E, out, 1: load a NOP into ID/EXE.
- flush_D, out, 1: load a NOP into IF/ID.
- interrupt_taken, out, 1: trap entry this cycle.
- interrupt_taken_reg, out, 1: interrupt_taken delayed one cycle.
- wfi_sleep, out, 1: core asleep.
- fdiv_busy, out, 1: divide occupying EXE.

Function
REQ-003 mem_hold = IM_stall | DM_stall; while mem_hold=1, the FSM, the counter and interrupt_taken_reg hold their values, and flush_E = flush_D = 0.
REQ-004 load_use = E_ld & !jb & a match on either source i, where D_use[i] = 1, D_rs_i == E_rd, D_src_fp[i] == E_ld_fp, and E_rd != 0 when the register is integer.
REQ-005 hold_E = mem_hold | fdiv_busy.
REQ-006 hold_FD = hold_E | load_use | wfi_sleep.
REQ-007 flush_E = !hold_E & (jb | load_use | interrupt_taken | interrupt_taken_reg | D_MRET | D_WFI).
REQ-008 flush_D = !hold_E & (jb | interrupt_taken).
REQ-009 FSM states: RUN and SLEEP; reset state is RUN.
REQ-010 RUN to SLEEP when D_WFI & !jb & !irq_pending & !hold_E.
REQ-011 SLEEP to RUN when irq_pending & !mem_hold.
REQ-012 wfi_sleep = (state == SLEEP).
REQ-013 interrupt_taken = irq_pending & !hold_E & !jb & !interrupt_taken_reg, in either state.
REQ-014 Priority of simultaneous events: mem_hold, then fdiv_busy, then jb, then interrupt, then D_MRET, then D_WFI.
- jb with D_WFI: no sleep.
- irq with D_MRET or D_WFI: the interrupt is taken and the MRET or WFI is flushed.
REQ-015 Divide counter, 4 bits, reset 0:
- Loads FDIV_LAT-1 when E_fdiv & !fdiv_busy & !mem_hold.
- Decrements by 1 when it is nonzero and !mem_hold.
- fdiv_busy = (counter != 0).
- Consequence: an fdiv holds EXE for exactly FDIV_LAT cycles with no memory stall, and each mem_hold cycle extends that.
REQ-016 interrupt_taken_reg is registered from interrupt_taken on every cycle without mem_hold.

Reset
REQ-017 Asynchronous rst drives the FSM to RUN, the counter to 0 and interrupt_taken_reg to 0, so every output reads 0 during reset with inputs quiet.
REQ-018 rst asserted mid-sleep or mid-divide aborts that operation, with no residual hold after release.

Configuration
REQ-019 FDIV_MULTICYCLE_EN defined: REQ-015 is active.
REQ-020 FDIV_MULTICYCLE_EN undefined: the counter is not instantiated, fdiv_busy is tied 0, and E_fdiv is ignored (single-cycle FPU).

Structure
REQ-021 Shared package core_pkg holds:
- the state enum (RUN, SLEEP);
- REG_ADDR_W = 5;
- the FDIV_LAT default.
REQ-022 Sub-module fdiv_occupancy_cnt holds the REQ-015 counter and is instantiated only under FDIV_MULTICYCLE_EN.

Verification
REQ-023 Load-use: E_ld=1, E_rd=5, D_rs1=5, D_use=01 -> hold_FD=1 and flush_E=1 for one cycle.
REQ-024 x0 load: the REQ-023 stimulus with E_rd=0 -> no stall.
REQ-025 FP mismatch: the REQ-023 stimulus with E_ld_fp=1 and D_src_fp=00 -> no stall.
REQ-026 WFI sleep: D_WFI=1 in RUN -> wfi_sleep=1 the next cycle and hold_FD=1 throughout.
REQ-027 WFI wake: irq_pending=1 after 10 cycles asleep -> interrupt_taken=1 for one cycle, then interrupt_taken_reg=1, with flush_E=1 in both cycles and state RUN.
REQ-028 Divide: E_fdiv=1 with FDIV_LAT=4 -> fdiv_busy=1 for 3 cycles (EXE occupied 4 cycles).
REQ-029 Divide under memory stall: DM_stall=1 for 2 cycles mid-divide -> fdiv_busy=1 for 5 cycles.
REQ-030 Simultaneous events: jb=1, D_WFI=1 and irq_pending=1 together -> flush_D=1, flush_E=1, interrupt_taken=0, no sleep.
REQ-031 Following cycle: interrupt_taken=1.
REQ-032 Reset: rst pulsed mid-sleep -> wfi_sleep=0 and fdiv_busy=0 immediately.
